// File: rtl/spike_rd_pkg.sv
// Shared FSM state type and default sizes for the spike FIFO reader.
package spike_rd_pkg;

    localparam int DEF_WIDTH = 9;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/spike_rd_stage.sv
// Output holding register: keeps one spike event stable until the consumer accepts it.
module spike_rd_stage
    import spike_rd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] addr_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] addr_q, addr_d;

    // A load in the same cycle as an accept replaces the event instead of emptying the stage.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (load_i) begin
            valid_d = 1'b1;
            addr_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;

endmodule

// File: rtl/spike_fifo_reader.sv
// Spike FIFO reader: drains a show-ahead event FIFO into a valid/ready stream per time step.
// Define SPIKE_READER_LOOKAHEAD_EN to allow a pop in the same cycle the held event is accepted.
module spike_fifo_reader
    import spike_rd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_pop_n,
    output logic             ev_valid,
    output logic [WIDTH-1:0] ev_addr,
    input  logic             ev_ready,
    input  logic             ts_req,
    output logic             ts_done,
    output logic [CNT_W-1:0] ev_count,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    rd_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             can_take;
    logic             pop_allowed;
    logic             pop;
    logic             accept;

    assign accept = ev_valid && ev_ready;

`ifdef SPIKE_READER_LOOKAHEAD_EN
    assign can_take = !ev_valid || ev_ready;
`else
    assign can_take = !ev_valid;
`endif

    // Dropping en in RUN stops popping at once; the held event still drains before IDLE.
    assign pop_allowed = ((state_q == RUN) && en) || (state_q == DRAIN);
    assign pop         = pop_allowed && !fifo_empty && can_take;
    assign fifo_pop_n  = ~pop;
    assign ts_done     = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign ev_count    = count_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ts_req) begin
                    state_d = DONE;
                end else if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ts_req) begin
                    state_d = DRAIN;
                end else if (!en && !ev_valid) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (fifo_empty && !ev_valid && !pop) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = en ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The count is visible throughout DONE and restarts on the edge that leaves it.
    always_comb begin
        count_d = count_q;
        if (state_q == DONE) begin
            count_d = '0;
        end else if (accept && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    spike_rd_stage #(
        .WIDTH(WIDTH)
    ) u_stage (
        .clk    (clk),
        .rst    (rst),
        .load_i (pop),
        .data_i (fifo_data),
        .ready_i(ev_ready),
        .valid_o(ev_valid),
        .addr_o (ev_addr)
    );

endmodule

// File: tb/tb_spike_fifo_reader.sv
// Self-checking bench for spike_fifo_reader: queue-based FIFO and delivery scoreboard.
module tb_spike_fifo_reader;

    localparam int WIDTH   = 9;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SPIKE_READER_LOOKAHEAD_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 2;
`endif

    logic             clk        = 1'b0;
    logic             rst        = 1'b1;
    logic             en         = 1'b0;
    logic             fifo_empty = 1'b1;
    logic [WIDTH-1:0] fifo_data  = '0;
    logic             fifo_pop_n;
    logic             ev_valid;
    logic [WIDTH-1:0] ev_addr;
    logic             ev_ready   = 1'b0;
    logic             ts_req     = 1'b0;
    logic             ts_done;
    logic [CNT_W-1:0] ev_count;
    logic             busy;

    logic [WIDTH-1:0] fifoQ[$];
    logic [WIDTH-1:0] pushQ[$];
    logic [WIDTH-1:0] acceptedQ[$];
    int               acceptCycleQ[$];

    int cycle      = 0;
    int popCount   = 0;
    int emptyPops  = 0;
    int holdViol   = 0;
    int doneCount  = 0;
    int sinceDone  = 0;
    logic             prevHold = 1'b0;
    logic [WIDTH-1:0] prevAddr = '0;

    int testCount = 0;
    int failCount = 0;

    spike_fifo_reader #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_pop_n(fifo_pop_n),
        .ev_valid  (ev_valid),
        .ev_addr   (ev_addr),
        .ev_ready  (ev_ready),
        .ts_req    (ts_req),
        .ts_done   (ts_done),
        .ev_count  (ev_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model plus scoreboard: records pops, accepted events and done pulses.
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (!fifo_pop_n) begin
            popCount <= popCount + 1;
            if (fifoQ.size() == 0) emptyPops <= emptyPops + 1;
            else fifoQ.delete(0);
        end
        if (rst) begin
            prevHold  <= 1'b0;
            sinceDone <= 0;
        end else begin
            if (prevHold && (!ev_valid || ev_addr !== prevAddr)) holdViol <= holdViol + 1;
            prevHold <= ev_valid && !ev_ready;
            prevAddr <= ev_addr;
            if (ev_valid && ev_ready) begin
                acceptedQ.push_back(ev_addr);
                acceptCycleQ.push_back(cycle);
                sinceDone <= sinceDone + 1;
            end
            if (ts_done) begin
                doneCount <= doneCount + 1;
                sinceDone <= 0;
            end
        end
        while (pushQ.size() > 0) fifoQ.push_back(pushQ.pop_front());
        fifo_empty <= (fifoQ.size() == 0);
        if (fifoQ.size() > 0) fifo_data <= fifoQ[0];
        else fifo_data <= '0;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int expCount();
        return (sinceDone > CNT_MAX) ? CNT_MAX : sinceDone;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic enV, input logic readyV, input logic tsV);
        en       = enV;
        ev_ready = readyV;
        ts_req   = tsV;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_pop_n"}, 32'(fifo_pop_n), 32'd1);
        checkOutput({tag, "_valid"}, 32'(ev_valid), 32'd0);
        checkOutput({tag, "_addr"}, 32'(ev_addr), 32'd0);
        checkOutput({tag, "_done"}, 32'(ts_done), 32'd0);
        checkOutput({tag, "_count"}, 32'(ev_count), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic waitAccepts(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && acceptedQ.size() < target; i++) tick();
        checkOutput(tag, 32'(acceptedQ.size() >= target), 32'd1);
    endtask

    task automatic checkSeq(input string tag, input int base, input logic [WIDTH-1:0] expQ[$]);
        int bad = 0;
        for (int i = 0; i < expQ.size(); i++) begin
            if (base + i >= acceptedQ.size()) bad++;
            else if (acceptedQ[base + i] !== expQ[i]) bad++;
        end
        checkOutput(tag, 32'(bad), 32'd0);
    endtask

    // Pulses ts_req, waits for the done pulse and checks the count shown with it and after it.
    task automatic runTimeStep(input string tag, input int expDoneCount);
        int doneBase = doneCount;
        ts_req = 1'b1;
        tick();
        ts_req = 1'b0;
        for (int i = 0; i < 40 && !ts_done; i++) tick();
        checkOutput({tag, "_done_seen"}, 32'(ts_done), 32'd1);
        checkOutput({tag, "_done_count"}, 32'(ev_count), 32'(expDoneCount));
        tick();
        checkOutput({tag, "_done_low"}, 32'(ts_done), 32'd0);
        checkOutput({tag, "_count_clr"}, 32'(ev_count), 32'd0);
        repeat (3) tick();
        checkOutput({tag, "_one_pulse"}, 32'(doneCount - doneBase), 32'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] expQ[$];
        int base;
        int pops0;

        $display("[TB] starting spike_fifo_reader bench, GAP=%0d", GAP);
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkResetValues("rst_init");
        repeat (2) tick();
        rst = 1'b0;

        // Two back-to-back events with the consumer always ready.
        base = acceptedQ.size();
        pushQ.push_back(9'h005);
        pushQ.push_back(9'h1A3);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitAccepts("A_accepts", base + 2, 20);
        if (acceptedQ.size() >= base + 2) begin
            checkOutput("A_first", 32'(acceptedQ[base]), 32'h005);
            checkOutput("A_second", 32'(acceptedQ[base + 1]), 32'h1A3);
            checkOutput("A_gap", 32'(acceptCycleQ[base + 1] - acceptCycleQ[base]), 32'(GAP));
        end
        checkOutput("A_count", 32'(ev_count), 32'd2);

        // Consumer stalls for five cycles with three entries queued.
        applyStimulus(1'b1, 1'b0, 1'b0);
        base  = acceptedQ.size();
        pops0 = popCount;
        pushQ.push_back(9'h011);
        pushQ.push_back(9'h022);
        pushQ.push_back(9'h033);
        for (int i = 0; i < 10 && ev_valid !== 1'b1; i++) tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("B_pop_n", 32'(fifo_pop_n), 32'd1);
            checkOutput("B_valid", 32'(ev_valid), 32'd1);
            checkOutput("B_addr", 32'(ev_addr), 32'h011);
            tick();
        end
        checkOutput("B_pops", 32'(popCount - pops0), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitAccepts("B_accepts", base + 3, 30);
        expQ = '{9'h011, 9'h022, 9'h033};
        checkSeq("B_order", base, expQ);
        checkOutput("B_count", 32'(ev_count), 32'(expCount()));

        runTimeStep("C", 5);

        // Time-step end raised together with four queued entries: all must drain first.
        base = acceptedQ.size();
        pushQ.push_back(9'h101);
        pushQ.push_back(9'h102);
        pushQ.push_back(9'h103);
        pushQ.push_back(9'h104);
        runTimeStep("D", 4);
        expQ = '{9'h101, 9'h102, 9'h103, 9'h104};
        checkSeq("D_order", base, expQ);

        // ts_req from IDLE with nothing queued.
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (2) tick();
        checkOutput("E_idle_busy", 32'(busy), 32'd0);
        pops0 = popCount;
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("E_done", 32'(ts_done), 32'd1);
        checkOutput("E_count", 32'(ev_count), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("E_done_low", 32'(ts_done), 32'd0);
        checkOutput("E_busy", 32'(busy), 32'd0);
        checkOutput("E_no_pop", 32'(popCount - pops0), 32'd0);

        // Reset while an event is held: it is discarded and nothing pops during reset.
        applyStimulus(1'b1, 1'b0, 1'b0);
        pushQ.push_back(9'h0AA);
        pushQ.push_back(9'h155);
        for (int i = 0; i < 10 && ev_valid !== 1'b1; i++) tick();
        checkOutput("F_valid_before", 32'(ev_valid), 32'd1);
        pops0 = popCount;
        rst = 1'b1;
        #1;
        checkResetValues("F_rst");
        repeat (2) begin
            tick();
            checkOutput("F_rst_pop_n", 32'(fifo_pop_n), 32'd1);
        end
        checkOutput("F_rst_pops", 32'(popCount - pops0), 32'd0);
        rst = 1'b0;
        base = acceptedQ.size();
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitAccepts("F_accepts", base + 1, 20);
        expQ = '{9'h155};
        checkSeq("F_leftover", base, expQ);
        checkOutput("F_count", 32'(ev_count), 32'(expCount()));
        runTimeStep("F_ts", 1);

        // Random addresses and random back-pressure, enough events to saturate the counter.
        applyStimulus(1'b1, 1'b0, 1'b0);
        base = acceptedQ.size();
        expQ.delete();
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            expQ.push_back(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)));
            pushQ.push_back(expQ[i]);
        end
        for (int i = 0; i < 400 && acceptedQ.size() < base + expQ.size(); i++) begin
            ev_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        ev_ready = 1'b1;
        checkOutput("G_accepts", 32'(acceptedQ.size() - base), 32'(expQ.size()));
        checkSeq("G_order", base, expQ);
        checkOutput("G_sat", 32'(ev_count), 32'(CNT_MAX));
        checkOutput("G_model", 32'(ev_count), 32'(expCount()));
        runTimeStep("G_ts", CNT_MAX);

        checkOutput("empty_pops", 32'(emptyPops), 32'd0);
        checkOutput("hold_viol", 32'(holdViol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
